// File: rtl/atomik_pkg.sv
// Shared constants and helpers for the ATOMiK UART telemetry path:
// frame layout, frame/serializer state encodings and the frame byte selector.
package atomik_pkg;

  // Frame layout: sync byte, four data bytes (MSB first), XOR checksum.
  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam logic [2:0] FRAME_LEN     = 3'd6;
  localparam logic [2:0] LAST_BYTE_IDX = FRAME_LEN - 3'd1;

  // Frame sequencer states.
  localparam logic [1:0] FRM_IDLE = 2'd0;
  localparam logic [1:0] FRM_LOAD = 2'd1;
  localparam logic [1:0] FRM_SEND = 2'd2;

  // Byte serializer states.
  localparam logic [1:0] SER_IDLE  = 2'd0;
  localparam logic [1:0] SER_START = 2'd1;
  localparam logic [1:0] SER_DATA  = 2'd2;
  localparam logic [1:0] SER_STOP  = 2'd3;

  // XOR of the four data bytes of a word.
  function automatic logic [7:0] frame_checksum(input logic [31:0] word);
    return word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
  endfunction

  // Byte at position idx of the frame carrying word.
  function automatic logic [7:0] frame_byte(input logic [31:0] word, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = word[31:24];
      3'd2:    b = word[23:16];
      3'd3:    b = word[15:8];
      3'd4:    b = word[7:0];
      3'd5:    b = frame_checksum(word);
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/atomik_uart_tx_byte.sv
// 8N1 byte serializer. A start request is taken only while ready=1. ready is
// also high during the last cycle of a stop bit, so a new byte can follow
// with no idle gap on the line.
module atomik_uart_tx_byte import atomik_pkg::*; #(
  parameter int BAUD_DIV = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int             CNT_W      = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BAUD_DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             tx_q, tx_d;
  logic             bit_end_s;

  assign bit_end_s = (cnt_q == '0);
  assign ready     = (state_q == SER_IDLE) || ((state_q == SER_STOP) && bit_end_s);
  assign tx        = tx_q;

  // Next-state logic: the baud counter reloads at every bit boundary.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    byte_d    = byte_q;
    tx_d      = tx_q;
    case (state_q)
      SER_IDLE: begin
        if (start) begin
          byte_d  = data;
          cnt_d   = CNT_RELOAD;
          tx_d    = 1'b0;
          state_d = SER_START;
        end else begin
          tx_d    = 1'b1;
        end
      end
      SER_START: begin
        if (bit_end_s) begin
          cnt_d     = CNT_RELOAD;
          bit_idx_d = 3'd0;
          tx_d      = byte_q[0];
          state_d   = SER_DATA;
        end else begin
          cnt_d     = cnt_q - CNT_W'(1);
        end
      end
      SER_DATA: begin
        if (bit_end_s) begin
          cnt_d = CNT_RELOAD;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = SER_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = byte_q[bit_idx_d];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SER_STOP: begin
        if (bit_end_s) begin
          if (start) begin
            byte_d  = data;
            cnt_d   = CNT_RELOAD;
            tx_d    = 1'b0;
            state_d = SER_START;
          end else begin
            tx_d    = 1'b1;
            state_d = SER_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = SER_IDLE;
      end
    endcase
  end

  // Serializer registers; reset drives the line high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SER_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      byte_q    <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      byte_q    <= byte_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: rtl/atomik_uart_telemetry.sv
// Telemetry transmitter: buffers core result words in a small FIFO and sends
// each as a 6-byte UART frame (sync, data MSB first, XOR checksum). Frames
// follow each other with no idle bits; the next sync byte is launched in the
// same cycle the next word is popped.
module atomik_uart_telemetry import atomik_pkg::*; #(
  parameter int CLK_FREQ   = 81_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   data_in,
  input  logic                          data_valid,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("atomik_uart_telemetry: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("atomik_uart_telemetry: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             busy_q, busy_d;
  logic [1:0]       frm_state_q, frm_state_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      word_q, word_d;
  logic             fifo_empty_s, fifo_full_s, push_s, pop_s;
  logic             ser_start_s, ser_ready_s;
  logic [7:0]       ser_byte_s;

  assign fifo_empty_s = (count_q == '0);
  assign fifo_full_s  = (count_q == LVL_FULL);
  assign tx_busy      = busy_q;
  assign overflow     = overflow_q;
  assign fifo_level   = count_q;

  // Frame sequencer: pop a word, launch the sync byte, then step through the frame.
  always_comb begin
    frm_state_d = frm_state_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    pop_s       = 1'b0;
    ser_start_s = 1'b0;
    ser_byte_s  = SYNC_BYTE;
    case (frm_state_q)
      FRM_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          word_d      = mem_q[rd_ptr_q];
          frm_state_d = FRM_LOAD;
        end else begin
          frm_state_d = FRM_IDLE;
        end
      end
      FRM_LOAD: begin
        // When chained from a previous frame the sync byte is already in flight.
        byte_idx_d  = 3'd0;
        frm_state_d = FRM_SEND;
        if (ser_ready_s) begin
          ser_start_s = 1'b1;
        end else begin
          ser_start_s = 1'b0;
        end
      end
      FRM_SEND: begin
        if (ser_ready_s) begin
          if (byte_idx_q != LAST_BYTE_IDX) begin
            ser_start_s = 1'b1;
            ser_byte_s  = frame_byte(word_q, byte_idx_q + 3'd1);
            byte_idx_d  = byte_idx_q + 3'd1;
          end else if (!fifo_empty_s) begin
            pop_s       = 1'b1;
            word_d      = mem_q[rd_ptr_q];
            ser_start_s = 1'b1;
            frm_state_d = FRM_LOAD;
          end else begin
            frm_state_d = FRM_IDLE;
          end
        end else begin
          frm_state_d = FRM_SEND;
        end
      end
      default: frm_state_d = FRM_IDLE;
    endcase
  end

  // FIFO bookkeeping: a write into a full FIFO is kept only if a pop frees a slot.
  always_comb begin
    push_s   = data_valid && (!fifo_full_s || pop_s);
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q || (data_valid && fifo_full_s && !pop_s);
    busy_d     = (count_d != '0) || (frm_state_d != FRM_IDLE);
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      frm_state_q <= FRM_IDLE;
      byte_idx_q  <= 3'd0;
      word_q      <= 32'h0000_0000;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      frm_state_q <= frm_state_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
    end
  end

  atomik_uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx_byte (
    .clk   (clk),
    .rst_n (rst_n),
    .start (ser_start_s),
    .data  (ser_byte_s),
    .ready (ser_ready_s),
    .tx    (uart_tx)
  );

endmodule

// File: tb/tb_atomik_uart_telemetry.sv
// Self-checking bench for atomik_uart_telemetry: a line receiver decodes
// uart_tx into bytes with start times; expected frames are built from the
// words written.
module tb_atomik_uart_telemetry;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int FIFO_DEPTH = 4;
  localparam int BYTE_CYC   = 100;
  localparam int FRAME_CYC  = 600;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        data_valid = 1'b0;
  logic        uart_tx, tx_busy, overflow;
  logic [2:0]  fifo_level;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int frame_err = 0;
  int peak_level;
  int low_seen;
  bit track_peak = 1'b0;
  bit quiet_mon = 1'b0;
  logic [7:0] rx_q[$];
  int         rx_t[$];

  atomik_uart_telemetry #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge N, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  // Highest fifo_level seen while tracking is enabled.
  always @(negedge clk) begin
    if (!track_peak) peak_level <= 0;
    else if (int'(fifo_level) > peak_level) peak_level <= int'(fifo_level);
  end

  // Count low line samples while watching for unwanted activity.
  always @(negedge clk) begin
    if (!quiet_mon) low_seen <= 0;
    else if (uart_tx !== 1'b1) low_seen <= low_seen + 1;
  end

  // Line receiver: samples mid-bit, discards bytes interrupted by reset.
  initial begin : line_monitor
    logic [7:0] b;
    logic       s_bit, p_bit;
    int         t0;
    bit         ok;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        t0 = cyc; ok = 1'b1; b = 8'h00; s_bit = 1'b1; p_bit = 1'b0;
        for (int k = 1; k <= 95; k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) ok = 1'b0;
          if (k == 5) s_bit = uart_tx;
          else if (k == 95) p_bit = uart_tx;
          else if ((k % 10) == 5) b[(k - 15) / 10] = uart_tx;
        end
        if (ok) begin
          if (s_bit !== 1'b0 || p_bit !== 1'b1) frame_err++;
          rx_q.push_back(b);
          rx_t.push_back(t0);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: sync, data bytes MSB first, XOR of the data bytes.
  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k);
    logic [7:0] f [6];
    f[0] = 8'hA5;
    f[1] = w[31:24];
    f[2] = w[23:16];
    f[3] = w[15:8];
    f[4] = w[7:0];
    f[5] = f[1] ^ f[2] ^ f[3] ^ f[4];
    return f[k];
  endfunction

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Write words on consecutive edges; first_edge is the edge taking the first one.
  task automatic write_words(input logic [31:0] w[$], output int first_edge);
    @(negedge clk);
    first_edge = cyc + 1;
    foreach (w[i]) begin
      data_in = w[i];
      data_valid = 1'b1;
      @(negedge clk);
    end
    data_valid = 1'b0;
  endtask

  // Compare the received byte stream to back-to-back frames of words starting at s.
  task automatic check_frames(input string tag, input logic [31:0] w[$], input int s);
    int n;
    n = w.size() * 6;
    check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(n));
    for (int j = 0; j < n && j < rx_q.size(); j++) begin
      check($sformatf("%s_byte%0d", tag, j), {24'h0, rx_q[j]}, {24'h0, exp_byte(w[j / 6], j % 6)});
      check($sformatf("%s_time%0d", tag, j), 32'(rx_t[j]), 32'(s + BYTE_CYC * j));
    end
    rx_q.delete();
    rx_t.delete();
  endtask

  initial begin
    logic [31:0] words[$];
    int n0, s0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_fifo_level", {29'h0, fifo_level}, 32'h0);

    // Single word accepted on the very first edge after reset release.
    words = '{32'h1234_5678};
    rst_n = 1'b1;
    data_in = words[0];
    data_valid = 1'b1;
    n0 = cyc + 1;
    s0 = n0 + 2;
    @(negedge clk);
    data_valid = 1'b0;
    check("s1_level_after_write", {29'h0, fifo_level}, 32'h1);
    @(negedge clk);
    check("s1_level_after_pop", {29'h0, fifo_level}, 32'h0);
    check("s1_line_idle_at_pop", {31'h0, uart_tx}, 32'h1);
    check("s1_busy_at_pop", {31'h0, tx_busy}, 32'h1);
    @(negedge clk);
    check("s1_start_bit", {31'h0, uart_tx}, 32'h0);
    wait_cyc(s0 + FRAME_CYC - 1);
    check("s1_busy_last_stop", {31'h0, tx_busy}, 32'h1);
    @(negedge clk);
    check("s1_busy_after", {31'h0, tx_busy}, 32'h0);
    check("s1_line_after", {31'h0, uart_tx}, 32'h1);
    check_frames("s1", words, s0);

    // Four writes on consecutive cycles.
    words = '{32'h1, 32'h2, 32'h3, 32'h4};
    track_peak = 1'b1;
    write_words(words, n0);
    s0 = n0 + 2;
    wait_cyc(s0 + 4 * FRAME_CYC);
    check("s2_peak_level", 32'(peak_level), 32'h3);
    track_peak = 1'b0;
    check("s2_overflow", {31'h0, overflow}, 32'h0);
    check("s2_busy_after", {31'h0, tx_busy}, 32'h0);
    check_frames("s2", words, s0);

    // Fill the FIFO, then write while full in the same cycle as the chained pop.
    words.delete();
    repeat (5) words.push_back($urandom);
    write_words(words, n0);
    s0 = n0 + 2;
    wait_cyc(s0 + FRAME_CYC - 1);
    check("s4_level_full", {29'h0, fifo_level}, 32'h4);
    words.push_back($urandom);
    data_in = words[5];
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check("s4_level_unchanged", {29'h0, fifo_level}, 32'h4);
    check("s4_overflow", {31'h0, overflow}, 32'h0);
    wait_cyc(s0 + 6 * FRAME_CYC + 1);
    check("s4_busy_after", {31'h0, tx_busy}, 32'h0);
    check_frames("s4", words, s0);

    // Six writes into an idle FIFO: the sixth is dropped.
    words.delete();
    repeat (6) words.push_back($urandom);
    write_words(words, n0);
    s0 = n0 + 2;
    check("s3_level_full", {29'h0, fifo_level}, 32'h4);
    check("s3_overflow_set", {31'h0, overflow}, 32'h1);
    words.pop_back();
    wait_cyc(s0 + 5 * FRAME_CYC + 1);
    check("s3_overflow_sticky", {31'h0, overflow}, 32'h1);
    check("s3_busy_after", {31'h0, tx_busy}, 32'h0);
    check("s3_level_after", {29'h0, fifo_level}, 32'h0);
    check_frames("s3", words, s0);

    // Reset pulse in the middle of byte 2 (data byte 2 is zero, so the line is low).
    words = '{{8'($urandom), 8'h00, 16'($urandom)}};
    write_words(words, n0);
    s0 = n0 + 2;
    wait_cyc(s0 + 250);
    check("s5_line_low_before_rst", {31'h0, uart_tx}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("s5_line_high_in_rst", {31'h0, uart_tx}, 32'h1);
    check("s5_level_in_rst", {29'h0, fifo_level}, 32'h0);
    check("s5_busy_in_rst", {31'h0, tx_busy}, 32'h0);
    check("s5_overflow_in_rst", {31'h0, overflow}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet_mon = 1'b1;
    repeat (1500) @(negedge clk);
    check("s5_quiet_line", 32'(low_seen), 32'h0);
    quiet_mon = 1'b0;
    check("s5_nbytes", 32'(rx_q.size()), 32'h2);
    if (rx_q.size() >= 2) begin
      check("s5_byte0", {24'h0, rx_q[0]}, {24'h0, exp_byte(words[0], 0)});
      check("s5_byte1", {24'h0, rx_q[1]}, {24'h0, exp_byte(words[0], 1)});
    end
    rx_q.delete();
    rx_t.delete();

    // Normal operation after reset with random words.
    words.delete();
    repeat (2) words.push_back($urandom);
    write_words(words, n0);
    s0 = n0 + 2;
    wait_cyc(s0 + 2 * FRAME_CYC + 1);
    check("s6_busy_after", {31'h0, tx_busy}, 32'h0);
    check_frames("s6", words, s0);

    check("framing_errors", 32'(frame_err), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
